// File: rtl/string_driver_pkg.sv
// Shared timing helpers, state encoding and WS2812B defaults
// for the single- and multi-lane string drivers.
package string_driver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    RESET = 2'd2
  } state_e;

  localparam int WS_CLK_PERIOD_NS = 100;
  localparam int WS_T0H_NS        = 400;
  localparam int WS_T1H_NS        = 800;
  localparam int WS_TBIT_NS       = 1250;
  localparam int WS_RESET_NS      = 50000;

  function automatic int get_count(input int ns, input int clk_ns);
    return (ns + clk_ns - 1) / clk_ns;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/string_driver_multi_encoder.sv
// One lane of the string driver: turns the current bit and the
// shared tick into a registered WS2812B high/low level.
module ws_lane_encoder
  import string_driver_pkg::*;
#(
  parameter int PIXEL_BITS = 24,
  parameter int BW         = 5,
  parameter int TW         = 9,
  parameter int T0HC       = 4,
  parameter int T1HC       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PIXEL_BITS-1:0] shift_i,
  input  logic [BW-1:0]         bit_idx_i,
  input  logic [TW-1:0]         tick_i,
  input  logic                  mask_i,
  output logic                  sdo_o
);

  logic          cur_bit;
  logic [TW-1:0] high_len;
  logic          sdo_d;
  logic          sdo_q;

  always_comb begin
    cur_bit  = shift_i[bit_idx_i];
    high_len = cur_bit ? TW'(T1HC) : TW'(T0HC);
    sdo_d    = mask_i && (tick_i < high_len);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sdo_q <= 1'b0;
    else     sdo_q <= sdo_d;
  end

  assign sdo_o = sdo_q;

endmodule

// File: rtl/string_driver_multi.sv
// Multi-lane WS2812B string driver: shared bit timer, one-entry
// holding register and IDLE/SEND/RESET sequencer.
module string_driver_multi
  import string_driver_pkg::*;
#(
  parameter int CLK_PERIOD_NS = WS_CLK_PERIOD_NS,
  parameter int NUM_LANES     = 4,
  parameter int PIXEL_BITS    = 24,
  parameter int T0H_NS        = WS_T0H_NS,
  parameter int T1H_NS        = WS_T1H_NS,
  parameter int TBIT_NS       = WS_TBIT_NS,
  parameter int RESET_NS      = WS_RESET_NS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_LANES*PIXEL_BITS-1:0] pixel_data,
  input  logic [NUM_LANES-1:0]            pixel_mask,
  input  logic                            pixel_last,
  input  logic                            pixel_valid,
  output logic                            pixel_ready,
  output logic                            busy,
  output logic [NUM_LANES-1:0]            sdo
);

  localparam int T0HC   = get_count(T0H_NS, CLK_PERIOD_NS);
  localparam int T1HC   = get_count(T1H_NS, CLK_PERIOD_NS);
  localparam int TBITC  = get_count(TBIT_NS, CLK_PERIOD_NS);
  localparam int RESETC = get_count(RESET_NS, CLK_PERIOD_NS);
  localparam int TMAX   = (TBITC > RESETC) ? TBITC : RESETC;
  localparam int TW     = (clog2(TMAX) < 1) ? 1 : clog2(TMAX);
  localparam int BW     = (clog2(PIXEL_BITS) < 1) ? 1 : clog2(PIXEL_BITS);
  localparam int LW     = NUM_LANES * PIXEL_BITS;

  if (!(T0HC > 0 && T0HC < T1HC && T1HC < TBITC)) begin : g_bad_timing
    $error("string_driver_multi: need 0 < T0H < T1H < TBIT in cycles");
  end

  state_e         state_q, state_d;
  logic [TW-1:0]  tick_q, tick_d;
  logic [BW-1:0]  idx_q, idx_d;
  logic [LW-1:0]  shift_q, shift_d;
  logic [NUM_LANES-1:0] mask_q, mask_d;
  logic           last_q, last_d;
  logic [LW-1:0]  hold_data_q;
  logic [NUM_LANES-1:0] hold_mask_q;
  logic           hold_last_q;
  logic           hold_valid_q, hold_valid_d;
  logic           ready_q, ready_d;
  logic           accept;
  logic           unload;
  logic [NUM_LANES-1:0] lane_en;

  assign accept = pixel_valid && ready_q;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    mask_d  = mask_q;
    last_d  = last_q;
    unload  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hold_valid_q) begin
          state_d = SEND;
          unload  = 1'b1;
        end
      end
      SEND: begin
        if (tick_q == TW'(TBITC - 1)) begin
          tick_d = '0;
          if (idx_q != '0) idx_d = idx_q - 1'b1;
          else if (last_q) state_d = RESET;
          else if (hold_valid_q) unload = 1'b1;
          else state_d = IDLE;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      RESET: begin
        if (tick_q == TW'(RESETC - 1)) begin
          tick_d = '0;
          if (hold_valid_q) begin
            state_d = SEND;
            unload  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (unload) begin
      shift_d = hold_data_q;
      mask_d  = hold_mask_q;
      last_d  = hold_last_q;
      tick_d  = '0;
      idx_d   = BW'(PIXEL_BITS - 1);
    end
  end

  // ready stays low on the unload edge so it can never coincide with accept
  always_comb begin
    hold_valid_d = hold_valid_q;
    if (accept)      hold_valid_d = 1'b1;
    else if (unload) hold_valid_d = 1'b0;
    ready_d = !hold_valid_d && !unload;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      mask_q       <= '0;
      last_q       <= 1'b0;
      hold_data_q  <= '0;
      hold_mask_q  <= '0;
      hold_last_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      mask_q       <= mask_d;
      last_q       <= last_d;
      hold_valid_q <= hold_valid_d;
      ready_q      <= ready_d;
      if (accept) begin
        hold_data_q <= pixel_data;
        hold_mask_q <= pixel_mask;
        hold_last_q <= pixel_last;
      end
    end
  end

  assign lane_en     = mask_q & {NUM_LANES{state_q == SEND}};
  assign busy        = (state_q != IDLE);
  assign pixel_ready = ready_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    ws_lane_encoder #(
      .PIXEL_BITS (PIXEL_BITS),
      .BW         (BW),
      .TW         (TW),
      .T0HC       (T0HC),
      .T1HC       (T1HC)
    ) u_enc (
      .clk       (clk),
      .rst       (rst),
      .shift_i   (shift_q[i*PIXEL_BITS +: PIXEL_BITS]),
      .bit_idx_i (idx_q),
      .tick_i    (tick_q),
      .mask_i    (lane_en[i]),
      .sdo_o     (sdo[i])
    );
  end

endmodule

// File: tb/tb_string_driver_multi.sv
// Directed bench for string_driver_multi: pixel waveforms,
// back-to-back streaming, latch gap, masks, reset, 32-bit pixels.
module tb_string_driver_multi;

  localparam int LOGN = 8192;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] pixel_data;
  logic [3:0]  pixel_mask;
  logic        pixel_last;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        busy;
  logic [3:0]  sdo;

  logic [31:0] p2_data;
  logic        p2_valid;
  logic        p2_ready;
  logic        p2_busy;
  logic        p2_sdo;

  always #5 clk = ~clk;

  string_driver_multi u_dut (
    .clk         (clk),
    .rst         (rst),
    .pixel_data  (pixel_data),
    .pixel_mask  (pixel_mask),
    .pixel_last  (pixel_last),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .busy        (busy),
    .sdo         (sdo)
  );

  string_driver_multi #(
    .NUM_LANES  (1),
    .PIXEL_BITS (32)
  ) u_dut32 (
    .clk         (clk),
    .rst         (rst),
    .pixel_data  (p2_data),
    .pixel_mask  (1'b1),
    .pixel_last  (1'b0),
    .pixel_valid (p2_valid),
    .pixel_ready (p2_ready),
    .busy        (p2_busy),
    .sdo         (p2_sdo)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] sdo_log  [LOGN];
  logic       busy_log [LOGN];
  logic       rdy_log  [LOGN];
  logic       sdo2_log [LOGN];
  logic       busy2_log[LOGN];

  always @(negedge clk) begin
    if (cyc < LOGN) begin
      sdo_log[cyc]   = sdo;
      busy_log[cyc]  = busy;
      rdy_log[cyc]   = pixel_ready;
      sdo2_log[cyc]  = p2_sdo;
      busy2_log[cyc] = p2_busy;
    end
  end

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [95:0] d, input logic [3:0] m,
                                   input int l, input int n);
    int b;
    int j;
    b = 23 - n / 13;
    j = n % 13;
    return m[l] && (j < (d[l*24 + b] ? 8 : 4));
  endfunction

  task automatic check_pixel(input string nm, input int base,
                             input logic [95:0] d, input logic [3:0] m,
                             input logic chk_hi, input logic [3:0][15:0] hi);
    for (int l = 0; l < 4; l++) begin
      int errs;
      int highs;
      errs  = 0;
      highs = 0;
      for (int n = 0; n < 312; n++) begin
        if (sdo_log[base + n][l] !== exp_bit(d, m, l, n)) errs++;
        if (sdo_log[base + n][l] === 1'b1) highs++;
      end
      check($sformatf("%s wave lane%0d", nm, l), errs, 0);
      if (chk_hi) check($sformatf("%s highs lane%0d", nm, l), highs, hi[l]);
    end
  endtask

  function automatic int count_busy(input int a, input int b);
    int c;
    c = 0;
    for (int i = a; i <= b; i++) if (busy_log[i] === 1'b1) c++;
    return c;
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic offer(input logic [95:0] d, input logic [3:0] m,
                       input logic l, output int t0);
    int w;
    w = 0;
    @(negedge clk);
    while (!pixel_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (!pixel_ready) check("offer ready timeout", pixel_ready, 1);
    pixel_data  = d;
    pixel_mask  = m;
    pixel_last  = l;
    pixel_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pixel_valid = 1'b0;
    t0 = cyc;
  endtask

  typedef struct {
    logic [95:0]      data;
    logic [3:0]       mask;
    logic [3:0][15:0] highs;
  } vec_t;

  vec_t vt [4];

  initial begin
    int t0;
    int t1;
    int errs;
    logic [95:0] pa;
    logic [95:0] pb;

    vt[0].data  = {24'h000000, 24'h000000, 24'h000000, 24'hFF0000};
    vt[0].mask  = 4'hF;
    vt[0].highs = {16'd96, 16'd96, 16'd96, 16'd128};
    vt[1].data  = {4{24'hFFFFFF}};
    vt[1].mask  = 4'b0101;
    vt[1].highs = {16'd0, 16'd192, 16'd0, 16'd192};
    vt[2].data  = {24'h123456, 24'hFFFFFF, 24'h000000, 24'hA5A5A5};
    vt[2].mask  = 4'hF;
    vt[2].highs = {16'd132, 16'd192, 16'd96, 16'd144};
    vt[3].data  = {4{24'hFFFFFF}};
    vt[3].mask  = 4'h0;
    vt[3].highs = {16'd0, 16'd0, 16'd0, 16'd0};

    rst         = 1'b1;
    pixel_data  = '0;
    pixel_mask  = '0;
    pixel_last  = 1'b0;
    pixel_valid = 1'b0;
    p2_data     = '0;
    p2_valid    = 1'b0;

    repeat (3) @(negedge clk);
    check("reset sdo", sdo, 0);
    check("reset busy", busy, 0);
    check("reset ready", pixel_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready after release", pixel_ready, 1);
    check("busy after release", busy, 0);

    for (int v = 0; v < 4; v++) begin
      offer(vt[v].data, vt[v].mask, 1'b0, t0);
      wait_until(t0 + 318);
      check($sformatf("v%0d sdo s0", v), sdo_log[t0], 0);
      check($sformatf("v%0d sdo s1", v), sdo_log[t0 + 1], 0);
      check_pixel($sformatf("v%0d", v), t0 + 2, vt[v].data, vt[v].mask,
                  1'b1, vt[v].highs);
      check($sformatf("v%0d busy cycles", v), count_busy(t0 + 1, t0 + 313), 312);
      check($sformatf("v%0d busy end", v), busy_log[t0 + 313], 0);
    end

    pa = {4{24'hF0F0F0}};
    pb = {4{24'h0F0F0F}};
    offer(pa, 4'hF, 1'b0, t0);
    offer(pb, 4'hF, 1'b0, t1);
    wait_until(t0 + 630);
    check("b2b ready s0", rdy_log[t0], 0);
    check("b2b ready s1", rdy_log[t0 + 1], 0);
    check("b2b ready s2", rdy_log[t0 + 2], 1);
    check("b2b second accept edge", t1, t0 + 3);
    errs = 0;
    for (int i = 3; i <= 313; i++) if (rdy_log[t0 + i] !== 1'b0) errs++;
    check("b2b ready low while held", errs, 0);
    check("b2b ready rise", rdy_log[t0 + 314], 1);
    check_pixel("b2b p1", t0 + 2, pa, 4'hF, 1'b0, '0);
    check_pixel("b2b p2", t0 + 314, pb, 4'hF, 1'b0, '0);
    check("b2b no gap", sdo_log[t0 + 314], 4'hF);
    check("b2b busy cycles", count_busy(t0 + 1, t0 + 625), 624);

    pa = {4{24'hAAAAAA}};
    pb = {4{24'h800001}};
    offer(pa, 4'hF, 1'b1, t0);
    offer(pb, 4'hF, 1'b0, t1);
    wait_until(t0 + 1130);
    check_pixel("last p1", t0 + 2, pa, 4'hF, 1'b0, '0);
    errs = 0;
    for (int i = 314; i <= 813; i++) if (sdo_log[t0 + i] !== 4'h0) errs++;
    check("latch gap zeros", errs, 0);
    check("latch gap end", sdo_log[t0 + 813], 0);
    check("p2 start after gap", sdo_log[t0 + 814], 4'hF);
    check_pixel("last p2", t0 + 814, pb, 4'hF, 1'b0, '0);
    check("latch ready held", rdy_log[t0 + 813], 0);
    check("latch ready rise", rdy_log[t0 + 814], 1);
    check("latch busy cycles", count_busy(t0 + 1, t0 + 1125), 1124);

    pa = {4{24'hFFFFFF}};
    offer(pa, 4'hF, 1'b0, t0);
    offer(pa, 4'hF, 1'b0, t1);
    wait_until(t0 + 100);
    check("pre-rst sdo", sdo, 4'hF);
    check("pre-rst hold", u_dut.hold_valid_q, 1);
    rst = 1'b1;
    #1;
    check("async rst sdo", sdo, 0);
    check("async rst busy", busy, 0);
    check("async rst hold", u_dut.hold_valid_q, 0);
    check("async rst ready", pixel_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post-rst ready", pixel_ready, 1);
    errs = 0;
    repeat (40) begin
      @(negedge clk);
      if (sdo !== 4'h0 || busy !== 1'b0) errs++;
    end
    check("post-rst quiet", errs, 0);

    begin
      logic [31:0] v32;
      int w;
      int hi;
      v32 = 32'h80000001;
      w   = 0;
      @(negedge clk);
      while (!p2_ready && w < 2000) begin
        @(negedge clk);
        w++;
      end
      check("p32 ready", p2_ready, 1);
      p2_data  = v32;
      p2_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      p2_valid = 1'b0;
      t0 = cyc;
      wait_until(t0 + 420);
      errs = 0;
      hi   = 0;
      for (int n = 0; n < 416; n++) begin
        int b;
        int j;
        logic e;
        b = 31 - n / 13;
        j = n % 13;
        e = (j < (v32[b] ? 8 : 4));
        if (sdo2_log[t0 + 2 + n] !== e) errs++;
        if (sdo2_log[t0 + 2 + n] === 1'b1) hi++;
      end
      check("p32 wave", errs, 0);
      check("p32 highs", hi, 136);
      errs = 0;
      for (int i = t0 + 1; i <= t0 + 417; i++) if (busy2_log[i] === 1'b1) errs++;
      check("p32 busy cycles", errs, 416);
      check("p32 busy end", busy2_log[t0 + 417], 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
